// File: rtl/present_decrypt_core.sv
// PRESENT-80 decryption core: key schedule is rolled forward to K32 on the fly,
// then one inverse round per cycle walks the key schedule back down.
package present_dec_pkg;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  4'hF: sbox = 4'h2;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  4'hF: inv_sbox = 4'hA;
      default: inv_sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ c;
    return t;
  endfunction

  // Exact inverse of key_fwd: undo the counter XOR, then the S-box, then the rotation.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ c;
    t[79:76] = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// Inverse round layer: inverse bit permutation followed by nibble-wise inverse S-box.
module present_inv_layer (
  input  logic [63:0] state_i,
  output logic [63:0] state_o
);
  import present_dec_pkg::*;

  logic [63:0] perm_s;

  for (genvar j = 0; j < 63; j++) begin : g_invp
    assign perm_s[(4 * j) % 63] = state_i[j];
  end
  assign perm_s[63] = state_i[63];

  for (genvar n = 0; n < 16; n++) begin : g_invs
    assign state_o[4 * n +: 4] = inv_sbox(perm_s[4 * n +: 4]);
  end

endmodule

module present_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        busy,
  output logic        done
);
  import present_dec_pkg::*;

  typedef enum logic [1:0] {IDLE, KEYGEN, WHITEN, DEC} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] st_q, st_d;
  logic [79:0] key_q, key_d;
  logic [63:0] data_q, data_d;
  logic        done_q, done_d;
  logic [63:0] inv_layer_s;
  logic [79:0] kp_s;

  present_inv_layer u_inv_layer (
    .state_i (st_q),
    .state_o (inv_layer_s)
  );

  assign kp_s = key_inv(key_q, cnt_q);

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    key_d  = key_q;
    data_d = data_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d  = data_i;
          key_d = key_i;
          cnt_d = 5'd1;
          fsm_d = KEYGEN;
        end else begin
          fsm_d = IDLE;
        end
      end
      KEYGEN: begin
        key_d = key_fwd(key_q, cnt_q);
        if (cnt_q == 5'd31) begin
          fsm_d = WHITEN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WHITEN: begin
        st_d  = st_q ^ key_q[79:16];
        cnt_d = 5'd31;
        fsm_d = DEC;
      end
      DEC: begin
        st_d  = inv_layer_s ^ kp_s[79:16];
        key_d = kp_s;
        cnt_d = cnt_q - 5'd1;
        // The cnt=1 round recovers the plaintext.
        if (cnt_q == 5'd1) begin
          data_d = inv_layer_s ^ kp_s[79:16];
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          fsm_d = DEC;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= 5'd0;
      st_q   <= 64'd0;
      key_q  <= 80'd0;
      data_q <= 64'd0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      key_q  <= key_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign data_o = data_q;
  assign done   = done_q;
  assign busy   = (fsm_q != IDLE);

endmodule

// File: tb/tb_present_decrypt_core.sv
// Bench for present_decrypt_core: ciphertexts come from a plain PRESENT-80
// encryption model, so a correct decryptor must return the original plaintext.
module tb_present_decrypt_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] SBOX_TAB = 64'hC56B90AD3EF84712;
  localparam logic [79:0] K_ONES   = {80{1'b1}};
  localparam logic [63:0] D_ONES   = {64{1'b1}};

  always #5 clk = ~clk;

  present_decrypt_core dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key_i  (key_i),
    .data_i (data_i),
    .data_o (data_o),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX_TAB[63 - 4 * int'(x) -: 4];
  endfunction

  // Textbook PRESENT-80 encryption: 31 rounds of addkey/sbox/player, then a final addkey.
  function automatic logic [63:0] enc(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s, t, p;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4 * n +: 4] = sb(s[4 * n +: 4]);
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Caller is at a falling edge; start is sampled on the next rising edge.
  task automatic launch(input logic [79:0] k, input logic [63:0] ct);
    start  = 1'b1;
    key_i  = k;
    data_i = ct;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts cycles after the start edge until done; scrambles inputs and optionally re-pulses start.
  task automatic wait_done(input int pa, input int pb, output int cyc, output int busy_lo);
    cyc = 0;
    busy_lo = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) busy_lo++;
      start  = (cyc == pa || cyc == pb);
      data_i = rnd64();
      key_i  = rnd80();
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [79:0] k, input logic [63:0] ct,
                        input logic [63:0] exp, input int pa, input int pb);
    int cyc, blo;
    launch(k, ct);
    wait_done(pa, pb, cyc, blo);
    chk({tag, "_latency"}, 80'(cyc), 80'd63);
    chk({tag, "_busy_low"}, 80'(blo), 80'd0);
    chk({tag, "_data"}, 80'(data_o), 80'(exp));
  endtask

  initial begin
    int cyc, blo, extra;
    logic [79:0] k;
    logic [63:0] pt, ct;

    // Reset with start held high: reset wins and start must not be remembered.
    rst    = 1'b1;
    start  = 1'b1;
    key_i  = rnd80();
    data_i = rnd64();
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_done", 80'(done), 80'd0);
    chk("rst_data", 80'(data_o), 80'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 80'(busy), 80'd0);

    run_op("v026", 80'd0, 64'h5579C1387B228445, 64'd0, -1, -1);
    @(negedge clk);
    chk("v026_done_pulse", 80'(done), 80'd0);
    chk("v026_hold", 80'(data_o), 80'd0);

    run_op("v027a", K_ONES, 64'hE72C46C0F5945049, 64'd0, -1, -1);
    run_op("v027b", 80'd0, 64'hA112FFC72F68417B, D_ONES, -1, -1);
    run_op("v028a", K_ONES, 64'h3333DCD3213210D2, D_ONES, -1, -1);

    // Back-to-back: start in the done cycle; next done lands 64 cycles after the previous one.
    launch(80'd0, 64'h5579C1387B228445);
    chk("b2b_hold_prev", 80'(data_o), 80'(D_ONES));
    wait_done(-1, -1, cyc, blo);
    chk("b2b_latency", 80'(cyc + 1), 80'd64);
    chk("b2b_busy_low", 80'(blo), 80'd0);
    chk("b2b_data", 80'(data_o), 80'd0);

    // Start pulses while busy must be ignored.
    k  = rnd80();
    pt = rnd64();
    run_op("v029", k, enc(k, pt), pt, 10, 40);
    extra = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("v029_extra_done", 80'(extra), 80'd0);
    chk("v029_hold", 80'(data_o), 80'(pt));

    // Reset at edge E20 mid-operation.
    launch(rnd80(), rnd64());
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("v030_busy", 80'(busy), 80'd0);
    chk("v030_done", 80'(done), 80'd0);
    chk("v030_data", 80'(data_o), 80'd0);
    rst = 1'b0;
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("v030_no_done", 80'(extra), 80'd0);
    k  = rnd80();
    pt = rnd64();
    run_op("v030_fresh", k, enc(k, pt), pt, -1, -1);

    for (int i = 0; i < 8; i++) begin
      k  = rnd80();
      pt = rnd64();
      ct = enc(k, pt);
      run_op($sformatf("rand%0d", i), k, ct, pt, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
